// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the synchronous data memory.
//   bytes_f / off_f : derive bytes per word and the byte-offset width
//   state_e         : clear / idle controller states
//   resp_t          : one response pipeline entry {valid, err, data}
// The data field is sized for the widest supported word; narrower
// instances only use the low DATA_WIDTH bits and the rest stays zero.
package ram_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 1024;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    logic                      valid;
    logic                      err;
    logic [MAX_DATA_WIDTH-1:0] data;
  } resp_t;

  function automatic int unsigned bytes_f(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned off_f(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ram_resp_pipe.sv
// ram_resp_pipe: fixed-length shift register of response entries.
//   clk, rst : clock and synchronous active-high clear of every stage
//   in_i     : entry loaded into stage 0 on each rising edge
//   out_o    : entry leaving the last stage
// Stages shift unconditionally; there is no downstream backpressure.
module ram_resp_pipe
  import ram_pkg::*;
#(
  parameter int unsigned STAGES = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t in_i,
  output resp_t out_o
);

  resp_t stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_o = stage_q[STAGES-1];

endmodule

// File: rtl/data_ram_sync.sv
// data_ram_sync: synchronous word-organised data memory with byte-lane
// writes, a valid/ready request port and fixed-latency in-order responses.
//   clk, rst     : clock, synchronous active-high reset
//   req_*        : request (valid/ready, we, byte address, wdata, lane enables)
//   resp_*       : response (one-cycle valid pulse, rdata, err)
//   init_done    : high once the post-reset clear has finished
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready depends only on internal state, and
// responses are never stalled.
module data_ram_sync
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    init_done
);

  localparam int unsigned BYTES  = bytes_f(DATA_WIDTH);
  localparam int unsigned OFF    = off_f(DATA_WIDTH);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFF;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e              state_q, state_d;
  logic [MEM_AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  resp_t             pipe_in;
  resp_t             pipe_out;
  logic              unused_pipe_data;

  // ---------------- address decode ----------------
  assign word_idx     = req_addr[ADDR_WIDTH-1:OFF];
  assign mem_idx      = word_idx[MEM_AW-1:0];
  assign out_of_range = (word_idx >= IDX_W'(DEPTH));

  if (BYTES > 1) begin : g_align
    assign misaligned = |req_addr[OFF-1:0];
  end else begin : g_no_align
    assign misaligned = 1'b0;
  end

  assign req_err = misaligned | out_of_range;
  // A request arriving on a reset edge is dropped even if the FSM was idle.
  assign accept  = req_valid & req_ready & ~rst;

  // ---------------- clear / idle controller ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == MEM_AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign init_done = (state_q == IDLE);

  // ---------------- storage ----------------
  // Clear writes one word per cycle; afterwards only error-free accepted
  // writes touch the array, lane by lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (accept && req_we && !req_err) begin
        for (int b = 0; b < BYTES; b++) begin
          if (req_be[b]) begin
            mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Stage 0 of the pipeline is the registered array read; writes and
  // errored requests carry zero data.
  always_comb begin
    pipe_in = '0;
    if (accept) begin
      pipe_in.valid = 1'b1;
      pipe_in.err   = req_err;
      if (!req_we && !req_err) begin
        pipe_in.data[DATA_WIDTH-1:0] = mem[mem_idx];
      end
    end
  end

  ram_resp_pipe #(
    .STAGES (READ_LATENCY)
  ) u_resp_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  assign resp_valid       = pipe_out.valid;
  assign resp_err         = pipe_out.err;
  assign resp_rdata       = pipe_out.data[DATA_WIDTH-1:0];
  assign unused_pipe_data = ^pipe_out.data;

endmodule

// File: tb/tb_data_ram_sync.sv
// tb_data_ram_sync: scoreboard bench for data_ram_sync (DEPTH=16, latency 3).
module tb_data_ram_sync;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned RL    = 3;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          init_done;

  data_ram_sync #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DW:0]   exp_q[$];      // {err, rdata}
  int            exp_cyc_q[$];  // cycle count at which the response is sampled
  logic [DW-1:0] model_mem [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;
  int            resp_seen   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    int          ec;
    if (resp_valid === 1'b1) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp got err=%0d data=%h required no response (t=%0t)",
                 resp_err, resp_rdata, $time);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("resp_err_data", 64'({resp_err, resp_rdata}), 64'(e));
        check("resp_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_accept(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] idx;
    idx = addr / 4;
    if ((addr % 4) != 0 || idx >= DEPTH) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back({1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b0, model_mem[idx]});
    end
    // accepted at the coming edge (cyc+1); visible RL-1 edges after that
    exp_cyc_q.push_back(cyc + RL);
  endtask

  // ---------------- drivers ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (req_ready === 1'b1 && rst === 1'b0) model_accept(we, addr, wdata, be);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input bit hold_write);
    int seen0;
    int n;
    rst       = 1'b1;
    req_valid = hold_write;
    req_we    = 1'b1;
    req_addr  = 32'h0;
    req_wdata = 32'hFFFF_FFFF;
    req_be    = 4'hF;
    @(posedge clk); #1;
    exp_q.delete();
    exp_cyc_q.delete();
    seen0 = resp_seen;
    @(posedge clk); #1;
    check("rst_req_ready",  64'(req_ready),  64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_resp_err",   64'(resp_err),   64'd0);
    check("rst_init_done",  64'(init_done),  64'd0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (req_ready === 1'b1) break;
    end
    req_valid = 1'b0;
    check("clear_cycles", 64'(n), 64'(DEPTH));
    check("init_done_after_clear", 64'(init_done), 64'd1);
    check("no_resp_during_reset_clear", 64'(resp_seen - seen0), 64'd0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i * 4), 32'h0, 4'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] addr;
    int          r;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;

    // reset and clear, every word reads zero
    do_reset(1'b0);
    read_all();
    wait_drain();

    // byte lanes
    issue(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
    issue(1'b1, 32'h8, 32'h0000_00AA, 4'h1);
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    issue(1'b1, 32'hC, 32'h1234_5678, 4'h0);   // be=0: no change, no error
    issue(1'b0, 32'hC, 32'h0, 4'h0);
    wait_drain();

    // back-to-back, read right behind write
    issue(1'b1, 32'h0, 32'h11, 4'hF);
    issue(1'b1, 32'h4, 32'h22, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    issue(1'b1, 32'h14, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    wait_drain();

    // errors, then word 0 unchanged
    issue(1'b0, 32'h6, 32'h0, 4'h0);
    issue(1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF);
    issue(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0);
    wait_drain();

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 8)       addr = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 8) addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else             addr = 32'($urandom_range(DEPTH, DEPTH + 4) * 4);
        issue(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
      end
    end
    wait_drain();

    // reset in the middle of traffic
    issue(1'b1, 32'h10, 32'h55, 4'hF);
    wait_drain();
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    do_reset(1'b0);
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    wait_drain();

    // requests held during clear are ignored
    do_reset(1'b1);
    read_all();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_ram_sync.md
# data_ram_sync

Synchronous, parametrised data memory for the MIPS datapath, replacing the asynchronous tri-state RAM chip model. It accepts one request per cycle on a valid/ready interface and supports byte-lane write enables. Every accepted request returns exactly one in-order response after a fixed, configurable latency. After reset it clears itself before accepting traffic; alignment and range errors are flagged rather than silently aliased.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8, at least 8.
- ADDR_WIDTH, 32: width of the byte address.
- DEPTH, 1024: number of words; not required to be a power of two.
- READ_LATENCY, 1: cycles from request acceptance to response; legal range 1..4.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; low only during CLEAR.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  byte-lane write enables; bit i controls bits [8i+7:8i].
- resp_valid  out  1  response present for exactly one cycle.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errored requests.
- resp_err  out  1  request was misaligned or out of range.
- init_done  out  1  clearing has finished.

## Operation
- Accept: a request is accepted when req_valid and req_ready are both high at a rising edge. There is no backpressure on the response side.
- Addressing:
  - BYTES = DATA_WIDTH/8 and OFF = clog2(BYTES).
  - The word index is req_addr[ADDR_WIDTH-1:OFF].
  - Misaligned means req_addr[OFF-1:0] != 0. This check is absent when BYTES = 1.
  - Out of range means the word index is >= DEPTH.
  - An errored request leaves memory unchanged and its response carries err=1 and rdata=0.
- Write: each lane whose req_be bit is 1 is updated at the acceptance edge. Lanes with a 0 bit keep their old value. A write with be = 0 is legal: memory is unchanged and the response has err=0.
- Read: returns the memory contents as they stand after all earlier accepted writes. A read accepted one cycle after a write to the same word returns the new data.
- FSM states:
  - CLEAR: writes 0 to one word per cycle, counting indices 0..DEPTH-1. req_ready=0 and init_done=0.
  - IDLE: req_ready=1 and init_done=1.
- FSM transitions:
  - rst forces CLEAR with the counter at 0.
  - CLEAR moves to IDLE on the edge that writes word DEPTH-1.
  - IDLE stays in IDLE until the next rst.
- Response pipeline: READ_LATENCY stages, each holding valid, err and data. The stages shift every cycle.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0. The pipeline valid bits are cleared.
- Clear duration:
  - rst is deasserted before edge E0.
  - CLEAR writes one word on each of edges E0..E(DEPTH-1).
  - req_ready rises after edge E(DEPTH-1), so the first request can be accepted at edge E(DEPTH).
- Latency: a request accepted at edge N produces a response that is visible after edge N+READ_LATENCY−1. It can be sampled at edge N+READ_LATENCY.
- Throughput: one request per cycle. Responses come back in acceptance order with no gaps added by the block.
- Reset mid-operation: responses in flight are dropped and resp_valid=0 after the reset edge. Clearing restarts from index 0, and memory contents are not preserved.
- Requests presented while req_ready=0 are ignored. They produce no response and no side effect.

## Structure
- The shared package ram_pkg holds:
  - functions that derive BYTES and OFF;
  - the FSM state enum {CLEAR, IDLE};
  - a response struct {valid, err, data}.
- Sub-module ram_resp_pipe: a parametrised READ_LATENCY-stage shift register of response structs with synchronous clear.
- The storage array and byte-lane write logic live in the top module. The read is registered so that synthesis infers block RAM.

## Test plan
- Reset and clear (DEPTH=16):
  - Stimulus: assert rst for 2 cycles, then deassert.
  - Required: req_ready=0 for exactly 16 cycles, then 1.
  - Required: reading every word returns 0x00000000.
- Byte enables:
  - Stimulus: write 0xDEADBEEF to address 0x8 with be=1111, then write 0x000000AA with be=0001, then read 0x8.
  - Required: rdata=0xDEADBEAA, err=0.
- Back-to-back traffic (READ_LATENCY=3):
  - Stimulus: write 0x11 to 0x0 and 0x22 to 0x4, then read 0x0 and 0x4, on four consecutive cycles.
  - Required: four consecutive resp_valid pulses, starting 3 cycles after the first acceptance.
  - Required: reads return 0x11 and 0x22.
- Errors:
  - Stimulus: read at 0x6 (misaligned); write at byte address 4·DEPTH (out of range).
  - Required: err=1 and rdata=0 for both.
  - Required: word 0 is unchanged.
- Reset mid-operation:
  - Stimulus: issue 3 reads, then assert rst one cycle later.
  - Required: no resp_valid after the reset edge.
  - Required: the CLEAR phase repeats, and a word previously holding 0x55 reads 0 afterwards.
- Requests during CLEAR:
  - Stimulus: hold req_valid=1 with a write throughout the CLEAR phase.
  - Required: no response is produced and memory is all zeros after init_done rises.
